// File: rtl/zap_wb_burst_ram.sv
// Wishbone B4 single-port RAM with classic and linear incrementing-burst
// support, programmable wait states before the first acknowledge, byte
// enables, and a registered read path that is prefetched one cycle ahead so
// bursts sustain one word per cycle.
module zap_wb_burst_ram #(
  parameter int unsigned SIZE_BYTES  = 32'd65536,  // power of two, >= 64
  parameter int unsigned WAIT_STATES = 32'd1       // 0..15
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic [31:0] i_wb_adr,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic [2:0]  i_wb_cti,
  input  logic [1:0]  i_wb_bte,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_dat
);

  localparam int unsigned AW    = $clog2(SIZE_BYTES) - 2;  // word address width
  localparam int unsigned WORDS = SIZE_BYTES / 4;
  localparam logic [3:0]  WAIT_LAST = (WAIT_STATES != 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [2:0]  CTI_INCR  = 3'b010;
  localparam logic [2:0]  CTI_EOB   = 3'b111;
  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CLASSIC_ACK,
    S_BURST
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q,  addr_d;
  logic [3:0]      wait_q,  wait_d;
  logic            we_q,    we_d;
  logic            burst_q, burst_d;
  logic [31:0]     rd_q,    rd_d;
  logic            ack;
  logic            wr_en;
  logic            rd_en;

  logic [31:0]     mem [WORDS];

  // Upper address bits alias and the burst type is always treated as linear.
  logic unused_ok;
  assign unused_ok = &{1'b0, i_wb_adr[31:AW+2], i_wb_adr[1:0], i_wb_bte};

  // Next-state, acknowledge and memory-strobe decode for the transfer FSM.
  // NOTE: every output of this block gets a default first so no path leaves
  // it unassigned; otherwise synthesis would infer latches.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wait_d  = wait_q;
    we_d    = we_q;
    burst_d = burst_q;
    ack     = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_wb_cyc && i_wb_stb) begin
          addr_d  = i_wb_adr[AW+1:2];
          we_d    = i_wb_we;
          burst_d = (i_wb_cti == CTI_INCR);
          wait_d  = 4'd0;
          rd_en   = 1'b1;
          if (WAIT_STATES != 0)
            state_d = S_WAIT;
          else if (i_wb_cti == CTI_INCR)
            state_d = S_BURST;
          else
            state_d = S_CLASSIC_ACK;
        end
      end

      S_WAIT: begin
        rd_en = 1'b1;  // keep the first word prefetched
        if (!i_wb_cyc) begin
          state_d = S_IDLE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = burst_q ? S_BURST : S_CLASSIC_ACK;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end

      S_CLASSIC_ACK: begin
        ack     = i_wb_cyc;
        wr_en   = i_wb_cyc && we_q;
        state_d = S_IDLE;
      end

      S_BURST: begin
        if (!i_wb_cyc) begin
          state_d = S_IDLE;
        end else if (i_wb_stb) begin
          ack    = 1'b1;
          wr_en  = we_q;
          addr_d = addr_q + ADDR_ONE;  // wraps modulo the RAM size
          rd_en  = 1'b1;
          if (i_wb_cti == CTI_EOB)
            state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Reset wins over any bus activity in the same cycle.
    if (i_reset) begin
      ack   = 1'b0;
      wr_en = 1'b0;
    end
  end

  // Prefetch of the word for the next cycle, forwarding a same-cycle write.
  always_comb begin
    rd_d = rd_q;
    if (rd_en) begin
      rd_d = mem[addr_d];
      if (wr_en && (addr_d == addr_q)) begin
        for (int b = 0; b < 4; b++) begin
          if (i_wb_sel[b])
            rd_d[8*b +: 8] = i_wb_dat[8*b +: 8];
        end
      end
    end
  end

  // Control state and read-data register with synchronous reset.
  // NOTE: sequential state is assigned with <= so every register samples
  // values from before the clock edge, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wait_q  <= 4'd0;
      we_q    <= 1'b0;
      burst_q <= 1'b0;
      rd_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wait_q  <= wait_d;
      we_q    <= we_d;
      burst_q <= burst_d;
      rd_q    <= rd_d;
    end
  end

  // Byte-enabled write port.
  // NOTE: the array has no reset so it maps onto block RAM and its contents
  // survive a bus reset.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wb_sel[b])
          mem[addr_q][8*b +: 8] <= i_wb_dat[8*b +: 8];
      end
    end
  end

  assign o_wb_ack = ack;
  assign o_wb_dat = rd_q;

endmodule

// File: tb/tb_zap_wb_burst_ram.sv
// Scoreboard bench for zap_wb_burst_ram: the stimulus drives a fixed
// cycle schedule and queues the cycle and data of every acknowledge it
// expects; a monitor on the falling edge retires the queue and flags any
// acknowledge that is missing, early, late or spurious.
module tb_zap_wb_burst_ram;

  localparam int unsigned SIZE = 32'd65536;
  localparam int          WS   = 1;
  localparam logic [2:0]  CTI_CLASSIC = 3'b000;
  localparam logic [2:0]  CTI_INCR    = 3'b010;
  localparam logic [2:0]  CTI_EOB     = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [31:0] adr, dat;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic [31:0] rdat;

  typedef struct {
    int          cyc;
    bit          is_read;
    logic [31:0] dat;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          cyc_n = 0;
  bit          mon_en = 1'b0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] beat_dat [8];

  zap_wb_burst_ram #(
    .SIZE_BYTES (SIZE),
    .WAIT_STATES(32'd1)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_wb_cyc(cyc),
    .i_wb_stb(stb),
    .i_wb_adr(adr),
    .i_wb_we (we),
    .i_wb_dat(dat),
    .i_wb_sel(sel),
    .i_wb_cti(cti),
    .i_wb_bte(bte),
    .o_wb_ack(ack),
    .o_wb_dat(rdat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cyc_n);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    cyc = 1'b0;
    stb = 1'b0;
    we  = 1'b0;
    cti = CTI_CLASSIC;
  endtask

  task automatic expect_ack(input bit is_read, input logic [31:0] d, input string name);
    exp_t e;
    e.cyc     = cyc_n;
    e.is_read = is_read;
    e.dat     = d;
    e.name    = name;
    exp_q.push_back(e);
  endtask

  // Classic single transfer: request, WS wait cycles, ack cycle, one idle.
  task automatic classic(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] c,
                         input logic [31:0] exp_d, input string name);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s; cti = c;
    step();
    repeat (WS) step();
    expect_ack(!w, exp_d, name);
    step();
    idle_bus();
    step();
  endtask

  // Linear burst of n beats using beat_dat[] as write data or expected read
  // data; stb is dropped for stall_len cycles before beat stall_at.
  task automatic burst(input logic w, input logic [31:0] a, input int n,
                       input int stall_at, input int stall_len, input string name);
    int beat = 0;
    int stalled = 0;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = beat_dat[0]; sel = 4'hF; cti = CTI_INCR;
    step();
    repeat (WS) step();
    while (beat < n) begin
      if (beat == stall_at && stalled < stall_len) begin
        stb = 1'b0;
        stalled++;
      end else begin
        stb = 1'b1;
        adr = a + 32'(beat * 4);
        dat = beat_dat[beat];
        cti = (beat == n - 1) ? CTI_EOB : CTI_INCR;
        expect_ack(!w, beat_dat[beat], $sformatf("%s beat%0d", name, beat));
        beat++;
      end
      step();
    end
    idle_bus();
    step();
  endtask

  // Monitor: compares every cycle's acknowledge against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc_n) begin
        mon_e = exp_q.pop_front();
        check(ack === 1'b1, {mon_e.name, " ack"}, 32'(ack), 32'd1);
        if (mon_e.is_read)
          check(rdat === mon_e.dat, {mon_e.name, " data"}, rdat, mon_e.dat);
      end else begin
        check(ack === 1'b0, "no ack expected", 32'(ack), 32'd0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle_bus();
    adr = 32'd0; dat = 32'd0; sel = 4'h0; bte = 2'b00;
    repeat (3) step();
    check(ack === 1'b0, "reset ack", 32'(ack), 32'd0);
    check(rdat === 32'd0, "reset dat", rdat, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    step();

    // Classic write, read, then byte-lane write (with cti=111 as classic).
    classic(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, CTI_CLASSIC, 32'h0, "wr_100");
    classic(1'b0, 32'h0000_0100, 32'h0,         4'hF, CTI_CLASSIC, 32'hDEAD_BEEF, "rd_100");
    classic(1'b1, 32'h0000_0100, 32'h0000_AB00, 4'b0010, CTI_EOB, 32'h0, "wr_byte");
    classic(1'b0, 32'h0000_0100, 32'h0,         4'hF, CTI_CLASSIC, 32'hDEAD_ABEF, "rd_byte");

    // 8-beat write burst of k at 0x200+4k, then an 8-beat read burst.
    for (int k = 0; k < 8; k++) beat_dat[k] = 32'(k);
    burst(1'b1, 32'h0000_0200, 8, 99, 0, "wr_burst8");
    burst(1'b0, 32'h0000_0200, 8, 99, 0, "rd_burst8");

    // Wrapping bursts at the top of memory with a non-linear bte, read with a
    // two-cycle master stall before beat 2; then check the wrapped words
    // through plain and aliased classic reads.
    for (int k = 0; k < 4; k++) beat_dat[k] = 32'hCAFE_0000 + 32'(k);
    bte = 2'b01;
    burst(1'b1, SIZE - 32'd8, 4, 99, 0, "wr_wrap");
    burst(1'b0, SIZE - 32'd8, 4, 2, 2, "rd_wrap");
    bte = 2'b00;
    classic(1'b0, 32'h0000_0000, 32'h0, 4'hF, CTI_CLASSIC, 32'hCAFE_0002, "rd_w0");
    classic(1'b0, 32'hABCD_0004, 32'h0, 4'hF, CTI_CLASSIC, 32'hCAFE_0003, "rd_alias");

    // Abort a write by dropping cyc during its wait cycle.
    classic(1'b1, 32'h0000_0300, 32'h0BAD_F00D, 4'hF, CTI_CLASSIC, 32'h0, "wr_300");
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0000_0300; dat = 32'h1234_5678;
    sel = 4'hF; cti = CTI_CLASSIC;
    step();
    idle_bus();
    step();
    step();
    classic(1'b0, 32'h0000_0300, 32'h0, 4'hF, CTI_CLASSIC, 32'h0BAD_F00D, "rd_abort");

    // Reset asserted on the first beat of a write burst.
    classic(1'b1, 32'h0000_0400, 32'h1111_1111, 4'hF, CTI_CLASSIC, 32'h0, "wr_400");
    classic(1'b1, 32'h0000_0404, 32'h2222_2222, 4'hF, CTI_CLASSIC, 32'h0, "wr_404");
    classic(1'b0, 32'h0000_0400, 32'h0, 4'hF, CTI_CLASSIC, 32'h1111_1111, "rd_400_pre");
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0000_0400; dat = 32'hEEEE_EEEE;
    sel = 4'hF; cti = CTI_INCR;
    step();
    repeat (WS) step();
    rst = 1'b1;
    step();
    check(ack === 1'b0, "reset mid-burst ack", 32'(ack), 32'd0);
    check(rdat === 32'd0, "reset mid-burst dat", rdat, 32'd0);
    rst = 1'b0;
    idle_bus();
    step();
    classic(1'b0, 32'h0000_0400, 32'h0, 4'hF, CTI_CLASSIC, 32'h1111_1111, "rd_400_post");
    classic(1'b0, 32'h0000_0404, 32'h0, 4'hF, CTI_CLASSIC, 32'h2222_2222, "rd_404_post");

    repeat (2) step();
    check(exp_q.size() == 0, "scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
